// File: rtl/multi_pkg.sv
// Shared constants, FSM state type and partial-product shift helper for the
// 78x78 chunked sequential multiplier.
package multi_pkg;

    localparam int CHUNK_A = 26;
    localparam int CHUNK_B = 17;
    localparam int N_A     = 3;
    localparam int N_B     = 5;
    localparam int N_PP    = 15;
    localparam int PP_W    = CHUNK_A + CHUNK_B;
    localparam int SHIFT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit offset of partial product (i, j): 26*i + 17*j, at most 120.
    function automatic logic [SHIFT_W-1:0] pp_shift(input logic [1:0] i, input logic [2:0] j);
        pp_shift = ({6'd0, i} * 8'd26) + ({5'd0, j} * 8'd17);
    endfunction

endpackage

// File: rtl/mul_26x17_pipe.sv
// Unsigned 26x17 -> 43 multiplier with a DSP_LAT-stage output pipeline,
// standing in for the DSP macro.
module mul_26x17_pipe #(
    parameter int DSP_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [25:0] a,
    input  logic [16:0] b,
    output logic [42:0] p
);

    logic [42:0] stage_r [DSP_LAT];

    // Multiply into the first stage, then shift down the pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DSP_LAT; i++) begin
                stage_r[i] <= 43'd0;
            end
        end else begin
            stage_r[0] <= {17'd0, a} * {26'd0, b};
            for (int i = 1; i < DSP_LAT; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign p = stage_r[DSP_LAT-1];

endmodule

// File: rtl/multi_seq_78.sv
// Sequential 78x78 multiplier: fifteen 26x17 partial products issued one per
// cycle through a pipelined multiplier and summed into a 156-bit accumulator.
module multi_seq_78 #(
    parameter int RADIX   = 78,
    parameter int DSP_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RADIX-1:0]     a,
    input  logic [RADIX-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*RADIX-1:0]   prod,
    output logic                 busy
);

    import multi_pkg::*;

    state_t                 state_r;
    logic [RADIX-1:0]       a_r;
    logic [RADIX-1:0]       b_r;
    logic [3:0]             k_r;
    logic [1:0]             i_r;
    logic [2:0]             j_r;
    logic [3:0]             acc_cnt_r;
    logic [2*RADIX-1:0]     acc_r;
    logic [2*RADIX-1:0]     prod_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   busy_r;

    logic [CHUNK_A-1:0]     op_a_r;
    logic [CHUNK_B-1:0]     op_b_r;
    logic                   iss_v_r;
    logic [SHIFT_W-1:0]     iss_sh_r;
    logic                   tag_v_r  [DSP_LAT];
    logic [SHIFT_W-1:0]     tag_sh_r [DSP_LAT];

    logic [CHUNK_A-1:0]     a_chunk_s;
    logic [CHUNK_B-1:0]     b_chunk_s;
    logic [PP_W-1:0]        pp_s;
    logic [2*RADIX-1:0]     pp_ext_s;
    logic [2*RADIX-1:0]     acc_next_s;
    logic                   tag_v_out_s;
    logic [SHIFT_W-1:0]     tag_sh_out_s;

    mul_26x17_pipe #(.DSP_LAT(DSP_LAT)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (op_a_r),
        .b     (op_b_r),
        .p     (pp_s)
    );

    assign tag_v_out_s  = tag_v_r[DSP_LAT-1];
    assign tag_sh_out_s = tag_sh_r[DSP_LAT-1];

    // Operand chunk selection and accumulator update for the returning product.
    always_comb begin
        a_chunk_s = {CHUNK_A{1'b0}};
        b_chunk_s = {CHUNK_B{1'b0}};
        case (i_r)
            2'd0:    a_chunk_s = a_r[25:0];
            2'd1:    a_chunk_s = a_r[51:26];
            2'd2:    a_chunk_s = a_r[77:52];
            default: a_chunk_s = {CHUNK_A{1'b0}};
        endcase
        case (j_r)
            3'd0:    b_chunk_s = b_r[16:0];
            3'd1:    b_chunk_s = b_r[33:17];
            3'd2:    b_chunk_s = b_r[50:34];
            3'd3:    b_chunk_s = b_r[67:51];
            3'd4:    b_chunk_s = {7'd0, b_r[77:68]};
            default: b_chunk_s = {CHUNK_B{1'b0}};
        endcase
        pp_ext_s = {(2*RADIX){1'b0}};
        pp_ext_s[PP_W-1:0] = pp_s;
        if (tag_v_out_s) begin
            acc_next_s = acc_r + (pp_ext_s << tag_sh_out_s);
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Valid/shift tags travel alongside the multiplier pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DSP_LAT; i++) begin
                tag_v_r[i]  <= 1'b0;
                tag_sh_r[i] <= {SHIFT_W{1'b0}};
            end
        end else begin
            tag_v_r[0]  <= iss_v_r;
            tag_sh_r[0] <= iss_sh_r;
            for (int i = 1; i < DSP_LAT; i++) begin
                tag_v_r[i]  <= tag_v_r[i-1];
                tag_sh_r[i] <= tag_sh_r[i-1];
            end
        end
    end

    // Control FSM, issue register, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= {RADIX{1'b0}};
            b_r         <= {RADIX{1'b0}};
            k_r         <= 4'd0;
            i_r         <= 2'd0;
            j_r         <= 3'd0;
            acc_cnt_r   <= 4'd0;
            acc_r       <= {(2*RADIX){1'b0}};
            prod_r      <= {(2*RADIX){1'b0}};
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            op_a_r      <= {CHUNK_A{1'b0}};
            op_b_r      <= {CHUNK_B{1'b0}};
            iss_v_r     <= 1'b0;
            iss_sh_r    <= {SHIFT_W{1'b0}};
        end else begin
            iss_v_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        k_r        <= 4'd0;
                        i_r        <= 2'd0;
                        j_r        <= 3'd0;
                        acc_cnt_r  <= 4'd0;
                        acc_r      <= {(2*RADIX){1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ISSUE;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    iss_v_r  <= 1'b1;
                    op_a_r   <= a_chunk_s;
                    op_b_r   <= b_chunk_s;
                    iss_sh_r <= pp_shift(i_r, j_r);
                    if (k_r == 4'(N_PP - 1)) begin
                        state_r <= DRAIN;
                    end else begin
                        k_r <= k_r + 4'd1;
                        if (j_r == 3'(N_B - 1)) begin
                            j_r <= 3'd0;
                            i_r <= i_r + 2'd1;
                        end else begin
                            j_r <= j_r + 3'd1;
                        end
                    end
                    if (tag_v_out_s) begin
                        acc_r     <= acc_next_s;
                        acc_cnt_r <= acc_cnt_r + 4'd1;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                DRAIN: begin
                    if (tag_v_out_s) begin
                        acc_r     <= acc_next_s;
                        acc_cnt_r <= acc_cnt_r + 4'd1;
                        // The fifteenth returning product completes the sum.
                        if (acc_cnt_r == 4'(N_PP - 1)) begin
                            prod_r      <= acc_next_s;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign prod      = prod_r;

endmodule

// File: tb/tb_multi_seq_78.sv
// Directed bench for multi_seq_78: corner products, latency, backpressure,
// mid-operation reset and 1000 back-to-back random operations.
module tb_multi_seq_78;

    localparam int RADIX   = 78;
    localparam int DSP_LAT = 3;
    localparam int LAT     = 16 + DSP_LAT;
    localparam int PW      = 2 * RADIX;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [RADIX-1:0] a         = '0;
    logic [RADIX-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [PW-1:0]    prod;

    int checks = 0;
    int errors = 0;

    multi_seq_78 #(.RADIX(RADIX), .DSP_LAT(DSP_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RADIX-1:0] rand78();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[RADIX-1:0];
    endfunction

    // One full transaction from IDLE; hold = extra cycles out_ready stays low in DONE.
    task automatic run_op(input string tag, input logic [RADIX-1:0] av, input logic [RADIX-1:0] bv,
                          input logic [PW-1:0] exp, input int hold);
        int lat;
        logic [PW-1:0] held;
        @(negedge clk);
        check({tag, "_idle_rdy"}, PW'(in_ready), PW'(1));
        a = av; b = bv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0;
        check({tag, "_busy"}, PW'(busy), PW'(1));
        check({tag, "_rdy_low"}, PW'(in_ready), PW'(0));
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, PW'(lat), PW'(LAT));
        check({tag, "_prod"}, prod, exp);
        held = prod;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_prod"}, prod, held);
            check({tag, "_hold_valid"}, PW'(out_valid), PW'(1));
            check({tag, "_hold_rdy"}, PW'(in_ready), PW'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_rdy"}, PW'(in_ready), PW'(1));
        check({tag, "_post_valid"}, PW'(out_valid), PW'(0));
        check({tag, "_post_busy"}, PW'(busy), PW'(0));
    endtask

    initial begin
        logic [PW-1:0]    exp_max;
        logic [RADIX-1:0] ra;
        logic [RADIX-1:0] rb;
        logic [PW-1:0]    rexp;
        int               seen;
        int               lat;
        int               w;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", PW'(in_ready), PW'(0));
        check("rst_out_valid", PW'(out_valid), PW'(0));
        check("rst_busy", PW'(busy), PW'(0));
        check("rst_prod", prod, PW'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", PW'(in_ready), PW'(1));
        check("rel_busy", PW'(busy), PW'(0));

        // Directed corner products
        run_op("one", 78'd1, 78'd1, PW'(1), 0);
        exp_max = (~((156'd1 << 79) - 156'd1)) + 156'd1;
        run_op("max", {RADIX{1'b1}}, {RADIX{1'b1}}, exp_max, 0);
        run_op("p77", 78'd1 << 77, 78'd1 << 77, 156'd1 << 154, 0);
        run_op("a0b68", 78'h3FFFFFF, 78'd1 << 68, 156'h3FFFFFF << 68, 0);

        // Backpressure: out_ready low for 10 cycles in DONE
        run_op("hold", 78'd12345, 78'd678, PW'(8369910), 10);

        // Reset at T+8 abandons the operation
        @(negedge clk);
        a = {RADIX{1'b1}}; b = 78'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_busy", PW'(busy), PW'(0));
        check("mid_rst_rdy", PW'(in_ready), PW'(0));
        check("mid_rst_valid", PW'(out_valid), PW'(0));
        check("mid_rst_prod", prod, PW'(0));
        @(negedge clk);
        check("mid_rst_rel_rdy", PW'(in_ready), PW'(1));
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        check("mid_rst_no_valid", PW'(seen), PW'(0));
        run_op("after_rst", 78'd3, 78'd5, PW'(15), 0);

        // Back-to-back with in_valid held high; inputs scrambled while busy
        @(negedge clk);
        in_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = (n % 50 == 0) ? {RADIX{1'b1}} : rand78();
            rb = (n % 50 == 1) ? {RADIX{1'b1}} : rand78();
            rexp = {78'd0, ra} * {78'd0, rb};
            w = 0;
            while (in_ready !== 1'b1 && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("b2b_rdy", PW'(in_ready), PW'(1));
            a = ra; b = rb;
            @(negedge clk);
            a = rand78(); b = rand78();
            lat = 0;
            while (out_valid !== 1'b1 && lat < 200) begin
                @(negedge clk);
                lat++;
                a = rand78(); b = rand78();
            end
            check("b2b_latency", PW'(lat), PW'(LAT));
            check("b2b_prod", prod, rexp);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
